fetch_arbiter: RTL and testbench

FETCH_ARBITER -- requirements
Module: fetch_arbiter

---
 rtl/fetch_arb_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 46 ++++
 rtl/fetch_arbiter.sv | 133 +++++++++++++
 tb/tb_fetch_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fetch_arb_pkg                                                |
// | Description : Shared types and default sizing for the instruction fetch    |
// |               arbiter: FSM state encoding, grant encoding and the default  |
// |               ROM address width, data width and ROM read latency.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fetch_arb_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int ROM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    SEQ = 1'b0,
    PAR = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter2                                                  |
// | Description : Two-requester arbiter. A lone request wins outright; on a    |
// |               tie the requester that was not granted last wins.            |
// |               Build option FETCH_ARB_FIXED_PRIO_EN: ties always go to the  |
// |               parallel requester and last_grant_i is ignored.              |
// | Ports       : req_seq_i    - sequential requester request                  |
// |               req_par_i    - parallel requester request                    |
// |               last_grant_i - previous grant (0 = SEQ, 1 = PAR)             |
// |               grant_o      - winner (0 = SEQ, 1 = PAR), valid with valid_o |
// |               valid_o      - at least one request present                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arbiter2
  import fetch_arb_pkg::*;
(
  input  logic req_seq_i,
  input  logic req_par_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  logic tie_gnt;

`ifdef FETCH_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign tie_gnt           = PAR;
`else
  // Alternate: whoever was not served last goes first.
  assign tie_gnt = (last_grant_i == SEQ) ? PAR : SEQ;
`endif

  assign valid_o = req_seq_i | req_par_i;

  always_comb begin
    grant_o = SEQ;
    if (req_seq_i && req_par_i) grant_o = tie_gnt;
    else if (req_par_i)         grant_o = PAR;
    else                        grant_o = SEQ;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_arbiter                                                |
// | Description : Shares one instruction ROM read port between a sequential    |
// |               and a parallel fetch requester, one transaction at a time:   |
// |               IDLE -> ISSUE -> WAIT (ROM_LAT cycles) -> RESP -> IDLE.      |
// |               Build option FETCH_ARB_FIXED_PRIO_EN: ties always go to the  |
// |               parallel requester (default build: round-robin).             |
// | Ports       : clk, rst (async, active-high)                                |
// |               seqReq/seqAddr           - sequential request + address      |
// |               seqReady/seqData         - sequential response pulse + word  |
// |               parallelFlag/parallelAddress - parallel request + address    |
// |               parReady/parData         - parallel response pulse + word    |
// |               romEn/romAddr/romData    - ROM read port                     |
// |               busy                     - transaction in progress           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seqReq,
  input  logic [ADDR_W-1:0] seqAddr,
  output logic              seqReady,
  output logic [DATA_W-1:0] seqData,
  input  logic              parallelFlag,
  input  logic [ADDR_W-1:0] parallelAddress,
  output logic              parReady,
  output logic [DATA_W-1:0] parData,
  output logic              romEn,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic              busy
);

  localparam logic [2:0] LAT_CNT = 3'(ROM_LAT);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  grant_e              gnt_q, gnt_d;
  grant_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   seq_data_q, seq_data_d;
  logic [DATA_W-1:0]   par_data_q, par_data_d;

  logic                arb_gnt;
  logic                arb_valid;

  rr_arbiter2 u_arb (
    .req_seq_i    (seqReq),
    .req_par_i    (parallelFlag),
    .last_grant_i (last_q),
    .grant_o      (arb_gnt),
    .valid_o      (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= SEQ;
      last_q     <= SEQ;
      addr_q     <= '0;
      seq_data_q <= '0;
      par_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      seq_data_q <= seq_data_d;
      par_data_q <= par_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    addr_d     = addr_q;
    seq_data_d = seq_data_q;
    par_data_d = par_data_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = grant_e'(arb_gnt);
          last_d  = grant_e'(arb_gnt);
          // The address register doubles as romAddr, so it holds its
          // value outside ISSUE without any extra storage.
          addr_d  = (grant_e'(arb_gnt) == PAR) ? parallelAddress : seqAddr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_CNT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Last WAIT cycle is the one in which romData is valid.
        if (cnt_q == 3'd1) begin
          if (gnt_q == PAR) par_data_d = romData;
          else              seq_data_d = romData;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign romEn    = (state_q == ISSUE);
  assign romAddr  = addr_q;
  assign seqReady = (state_q == RESP) && (gnt_q == SEQ);
  assign parReady = (state_q == RESP) && (gnt_q == PAR);
  assign seqData  = seq_data_q;
  assign parData  = par_data_q;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_arbiter                                             |
// | Description : Self-checking bench for fetch_arbiter. A behavioural ROM     |
// |               returns a known word ROM_LAT cycles after each strobe;       |
// |               expected responses are queued when requests are driven and   |
// |               matched when a Ready pulse appears.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fetch_arbiter;

  parameter int ROM_LAT = 2;

  localparam int T_TXN = ROM_LAT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seqReq = 1'b0;
  logic [7:0]  seqAddr = '0;
  logic        seqReady;
  logic [31:0] seqData;
  logic        parallelFlag = 1'b0;
  logic [7:0]  parallelAddress = '0;
  logic        parReady;
  logic [31:0] parData;
  logic        romEn;
  logic [7:0]  romAddr;
  logic [31:0] romData;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit          par;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] last_seq_data = '0;
  logic [31:0] last_par_data = '0;

  fetch_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .seqReq          (seqReq),
    .seqAddr         (seqAddr),
    .seqReady        (seqReady),
    .seqData         (seqData),
    .parallelFlag    (parallelFlag),
    .parallelAddress (parallelAddress),
    .parReady        (parReady),
    .parData         (parData),
    .romEn           (romEn),
    .romAddr         (romAddr),
    .romData         (romData),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEAD_BEEF;
    return {a, ~a, a ^ 8'h5A, a + 8'h33};
  endfunction

  // ROM: address sampled at the end of the strobe cycle appears ROM_LAT
  // cycles after that strobe cycle.
  bit [7:0] pa [1:7];
  bit       pv [1:7];
  always @(posedge clk) begin
    pa[1] <= romAddr;
    pv[1] <= romEn;
    for (int i = 2; i <= 7; i++) begin
      pa[i] <= pa[i-1];
      pv[i] <= pv[i-1];
    end
  end
  assign romData = pv[ROM_LAT] ? rom(pa[ROM_LAT]) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit par, input logic [7:0] addr, input int c);
    exp_t e;
    e.par  = par;
    e.data = rom(addr);
    e.cyc  = c + ROM_LAT + 2;
    sb.push_back(e);
  endtask

  // Response monitor: every Ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (seqReady || parReady)) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {seqReady, parReady}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_who", {seqReady, parReady}, e.par ? 2'b01 : 2'b10);
        check("ready_cycle", cyc, e.cyc);
        if (e.par) begin
          check("parData", parData, e.data);
          check("seqData_hold", seqData, last_seq_data);
          last_par_data = e.data;
        end else begin
          check("seqData", seqData, e.data);
          check("parData_hold", parData, last_par_data);
          last_seq_data = e.data;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_romEn"},    romEn,    0);
    check({tag, "_romAddr"},  romAddr,  0);
    check({tag, "_seqReady"}, seqReady, 0);
    check({tag, "_parReady"}, parReady, 0);
    check({tag, "_seqData"},  seqData,  0);
    check({tag, "_parData"},  parData,  0);
    check({tag, "_busy"},     busy,     0);
  endtask

  // One requester alone; pulse=1 drops the request right after IDLE.
  task automatic single_req(input bit par, input logic [7:0] addr, input bit pulse);
    int c;
    c = cyc;
    if (par) begin parallelFlag = 1'b1; parallelAddress = addr; end
    else     begin seqReq = 1'b1;       seqAddr = addr;         end
    check("idle_busy", busy, 0);
    check("idle_romEn", romEn, 0);
    push_exp(par, addr, c);
    for (int k = 1; k <= T_TXN; k++) begin
      tick();
      check(k == 1 ? "issue_romEn" : "romEn_low", romEn, (k == 1) ? 1 : 0);
      check("romAddr", romAddr, addr);
      check("busy", busy, (k <= ROM_LAT + 2) ? 1 : 0);
      if (k == 1) begin
        // Address changes after latching must be ignored.
        if (par) parallelAddress = addr ^ 8'hA5;
        else     seqAddr         = addr ^ 8'hA5;
        if (pulse) begin parallelFlag = 1'b0; seqReq = 1'b0; end
      end
      if (k == ROM_LAT + 2) begin parallelFlag = 1'b0; seqReq = 1'b0; end
    end
  endtask

  // Both requesters held for n back-to-back transactions.
  task automatic tie_req(input bit first_par, input int n);
    int c0;
    bit g [0:7];
    c0 = cyc;
    seqReq = 1'b1;       seqAddr = 8'h01;
    parallelFlag = 1'b1; parallelAddress = 8'h02;
    for (int i = 0; i < n; i++) begin
`ifdef FETCH_ARB_FIXED_PRIO_EN
      g[i] = 1'b1;
`else
      g[i] = first_par ^ i[0];
`endif
      push_exp(g[i], g[i] ? 8'h02 : 8'h01, c0 + i * T_TXN);
    end
    for (int k = 1; k <= n * T_TXN; k++) begin
      tick();
      if (k % T_TXN == 1) begin
        check("tie_romEn", romEn, 1);
        check("tie_romAddr", romAddr, g[(k-1) / T_TXN] ? 8'h02 : 8'h01);
      end
      if (k == (n - 1) * T_TXN + ROM_LAT + 2) begin
        seqReq = 1'b0;
        parallelFlag = 1'b0;
      end
    end
  endtask

  task automatic reset_mid();
    seqReq = 1'b1; seqAddr = 8'h33;
    tick();                 // ISSUE
    seqReq = 1'b0;
    tick();                 // first WAIT cycle
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    last_seq_data = '0;
    last_par_data = '0;
    repeat (ROM_LAT + 4) tick();
    check("post_rst_busy", busy, 0);
  endtask

  initial begin
    #1 check_all_zero("reset");
    repeat (3) tick();
    check_all_zero("reset_hold");
    rst = 1'b0;
    tick();

    tie_req(1'b1, 3);               // first tie after reset: PAR, SEQ, PAR
    single_req(1'b1, 8'h7F, 1'b1);  // one-cycle parallel pulse
    tie_req(1'b0, 2);               // last grant PAR -> SEQ first
    single_req(1'b0, 8'h10, 1'b0);  // 0xDEADBEEF to sequential
    reset_mid();
    single_req(1'b0, 8'h55, 1'b0);  // normal service after reset
    single_req(1'b0, 8'hFF, 1'b0);
    tie_req(1'b1, 1);               // last grant SEQ -> PAR

    repeat (ROM_LAT + 4) tick();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
